// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program into instruction memory, then releases and starts the CPU
// Optional checksum register enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    input  logic                  word_last,
    output logic                  word_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  cpu_start,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  load_done,
    output logic                  load_error,
    output logic [31:0]           checksum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(MAX_WORDS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  word_ready_q, cpu_reset_q, cpu_start_q, load_error_q;
    logic                  accept;
    logic                  start_load;

    assign accept     = word_valid && (state_q == LOAD);
    assign start_load = load_req && (state_q == IDLE || state_q == RUN || state_q == ERROR);

    always_comb begin
        state_d        = state_q;
        words_loaded_d = words_loaded_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        if (start_load) begin
            state_d        = LOAD;
            words_loaded_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        imem_we_d      = 1'b1;
                        imem_addr_d    = words_loaded_q[ADDR_WIDTH-1:0];
                        imem_wdata_d   = word_data;
                        words_loaded_d = words_loaded_q + 1'b1;
                        // The final-capacity word is still written before flagging overflow.
                        if (word_last)
                            state_d = RELEASE;
                        else if (words_loaded_q == LAST_IDX)
                            state_d = ERROR;
                    end
                end
                RELEASE: state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // Decoded outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            words_loaded_q <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            word_ready_q   <= 1'b0;
            cpu_reset_q    <= 1'b1;
            cpu_start_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            words_loaded_q <= words_loaded_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            word_ready_q   <= (state_d == LOAD);
            cpu_reset_q    <= (state_d == IDLE) || (state_d == LOAD) || (state_d == ERROR);
            cpu_start_q    <= (state_d == RUN);
            load_error_q   <= (state_d == ERROR);
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_load)
            checksum_d = '0;
        else if (accept)
            checksum_d = checksum_q ^ word_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            checksum_q <= '0;
        else
            checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign word_ready   = word_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign cpu_start    = cpu_start_q;
    assign load_done    = cpu_start_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning program capacity in words (at most 2^ADDR_WIDTH).
REQ-003 SHALL have port clock  input  1  meaning single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port load_req  input  1  meaning start a load session.
REQ-006 SHALL have ports word_valid/word_data/word_last  input  1/32/1  meaning the program word stream; word_last marks the final word.
REQ-007 SHALL have port word_ready  output  1  meaning the loader accepts a word this cycle.
REQ-008 SHALL have ports imem_we/imem_addr/imem_wdata  output  1/ADDR_WIDTH/32  meaning the instruction-memory write port.
REQ-009 SHALL have ports cpu_reset/cpu_start  output  1/1  meaning the hold and start controls to the downstream single-cycle CPU.
REQ-010 SHALL have ports words_loaded/load_done/load_error  output  ADDR_WIDTH+1/1/1  meaning the accepted word count, program-running flag, and overflow flag.
REQ-011 SHALL have port checksum  output  32  meaning the XOR of the accepted words (see Configuration).

Function
REQ-012 SHALL implement the states IDLE, LOAD, RELEASE, RUN and ERROR, held in a registered state.
REQ-013 Outputs SHALL be decoded from state as follows:
- word_ready = 1 only in LOAD.
- cpu_reset = 1 in IDLE, LOAD and ERROR, and 0 in RELEASE and RUN.
- cpu_start = 1 and load_done = 1 only in RUN.
- load_error = 1 only in ERROR.
REQ-014 A word SHALL be accepted at a rising edge where word_valid and word_ready are both 1.
REQ-015 An accepted word SHALL produce a registered write on the next cycle: imem_we=1, imem_addr=words_loaded (pre-increment value), imem_wdata=word_data.
- imem_we SHALL be 0 in every other cycle.
REQ-016 words_loaded SHALL increment by 1 per accepted word and hold when word_valid=0.
REQ-017 IDLE->LOAD SHALL occur on load_req=1.
- Entering LOAD clears words_loaded to 0.
- A word_valid in the same cycle as load_req SHALL NOT be accepted.
REQ-018 LOAD->RELEASE SHALL occur when an accepted word has word_last=1.
REQ-019 LOAD->ERROR SHALL occur when the word accepted at index MAX_WORDS-1 has word_last=0; that word is still written.
REQ-020 RELEASE SHALL last exactly one cycle and then go to RUN, so cpu_start rises one cycle after cpu_reset falls.
REQ-021 RUN and ERROR SHALL go to LOAD on load_req=1, reasserting cpu_reset on the cycle after that edge.
- Otherwise both states hold.
REQ-022 load_req SHALL be ignored in LOAD and RELEASE.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, words_loaded=0, checksum=0
- imem_we=0, imem_addr=0, imem_wdata=0
- word_ready=0, cpu_start=0, load_done=0, load_error=0
- cpu_reset=1
REQ-024 reset asserted mid-LOAD SHALL abandon the session; the next session SHALL write from address 0.

Configuration
REQ-025 Macro PROGRAM_LOADER_CHECKSUM_EN SHALL control the checksum port.
- Defined: checksum clears on entering LOAD and XORs in each accepted word at the acceptance edge.
- Undefined: checksum is constant 0 and no checksum register is built.

Verification
REQ-026 Assert reset for 3 cycles -> cpu_reset=1, all other outputs 0, state IDLE.
REQ-027 Run load_req, then words 0x10220004, 0x00221820, 0x00432020 with last on the third ->
- imem writes to addr 0, 1 and 2 in consecutive cycles.
- words_loaded=3.
- cpu_reset falls one cycle after the last acceptance; cpu_start=load_done=1 one cycle after that.
- checksum=0x10433804 with the macro defined, 0 without it.
REQ-028 Same load with word_valid low for 2 cycles between words -> no imem_we during the gaps, words_loaded holds, final memory contents are identical.
REQ-029 MAX_WORDS=4, send 4 words with no last -> 4 writes (addr 0-3), load_error=1, cpu_reset=1, word_ready=0; a subsequent load_req returns to LOAD with words_loaded=0.
REQ-030 Assert reset after 2 accepted words, then perform a fresh 1-word load with last -> write to addr 0, words_loaded=1, reaches RUN.
REQ-031 Assert load_req while in RUN -> cpu_start=0 and cpu_reset=1 on the next cycle, words_loaded=0, word_ready=1.
